// File: rtl/pcie_perst_sequencer.sv
// PCIe PERST# reset sequencer.
// Synchronizes PERST# and IOPLL lock, then releases resets in order:
// PCIe HIP, then FIM fabric, then AFU. Any abort re-asserts the
// affected resets on the same edge the state changes.
module pcie_perst_sequencer #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYC    = 16,
    parameter int PLL_TIMEOUT_CYC = 4096,
    parameter int FABRIC_HOLD_CYC = 32,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcie_reset_n,
    input  logic             pll_locked,
    input  logic             link_up,
    output logic             hip_rst,
    output logic             fabric_rst,
    output logic             afu_rst,
    output logic [2:0]       seq_state,
    output logic             pll_timeout,
    output logic [CNT_W-1:0] perst_count
);

    localparam int MAX_A = (DEBOUNCE_CYC > PLL_TIMEOUT_CYC) ? DEBOUNCE_CYC : PLL_TIMEOUT_CYC;
    localparam int MAX_P = (MAX_A > FABRIC_HOLD_CYC) ? MAX_A : FABRIC_HOLD_CYC;
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] PLL_LAST = TW'(PLL_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] FAB_LAST = TW'(FABRIC_HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_PLL      = 3'd2,
        S_HIP      = 3'd3,
        S_FABRIC   = 3'd4,
        S_AFU      = 3'd5,
        S_UP       = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] perst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   perst_s;
    logic                   lock_s;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hip_q, hip_d;
    logic             fab_q, fab_d;
    logic             afu_q, afu_d;

    // Synchronizer chains; clearing to 0 reads as PERST asserted, PLL unlocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perst_sync_q <= '0;
            lock_sync_q  <= '0;
        end else begin
            perst_sync_q <= {perst_sync_q[SYNC_STAGES-2:0], pcie_reset_n};
            lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign perst_s = perst_sync_q[SYNC_STAGES-1];
    assign lock_s  = lock_sync_q[SYNC_STAGES-1];

    // Next-state: aborts in priority order, then the normal bring-up walk
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        count_d   = count_q;

        if (!perst_s && state_q != S_HOLD && state_q != S_DEBOUNCE) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            if (count_q != '1) count_d = count_q + 1'b1;
        end else if (!lock_s && (state_q == S_HIP || state_q == S_FABRIC ||
                                 state_q == S_AFU || state_q == S_UP)) begin
            state_d = S_PLL;
            cnt_d   = '0;
        end else if (!link_up && (state_q == S_FABRIC || state_q == S_AFU ||
                                  state_q == S_UP)) begin
            state_d = S_HIP;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (perst_s) begin
                        state_d = S_DEBOUNCE;
                        cnt_d   = '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!perst_s) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_PLL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PLL: begin
                    // After timeout the counter parks at its last value and waiting continues
                    if (lock_s) begin
                        state_d = S_HIP;
                        cnt_d   = '0;
                    end else if (cnt_q == PLL_LAST) begin
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HIP: begin
                    if (link_up) begin
                        state_d = S_FABRIC;
                        cnt_d   = '0;
                    end
                end
                S_FABRIC: begin
                    if (cnt_q == FAB_LAST) begin
                        state_d = S_AFU;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_AFU:   state_d = S_UP;
                S_UP:    state_d = S_UP;
                default: state_d = S_HOLD;
            endcase
        end

        hip_d = (state_d == S_HOLD) || (state_d == S_DEBOUNCE) || (state_d == S_PLL);
        fab_d = hip_d || (state_d == S_HIP) || (state_d == S_FABRIC);
        afu_d = (state_d != S_UP);
    end

    // State, counters and registered reset outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            hip_q     <= 1'b1;
            fab_q     <= 1'b1;
            afu_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            hip_q     <= hip_d;
            fab_q     <= fab_d;
            afu_q     <= afu_d;
        end
    end

    assign hip_rst     = hip_q;
    assign fabric_rst  = fab_q;
    assign afu_rst     = afu_q;
    assign seq_state   = state_q;
    assign pll_timeout = timeout_q;
    assign perst_count = count_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Bench for pcie_perst_sequencer: directed scenarios plus a random phase,
// all checked every edge against an elapsed-time reference model.
module tb_pcie_perst_sequencer;

    localparam int SYNC = 3;
    localparam int DEB  = 16;
    localparam int PTO  = 4096;
    localparam int FH   = 32;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pcie_reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          link_up = 1'b0;
    logic          hip_rst, fabric_rst, afu_rst, pll_timeout;
    logic [2:0]    seq_state;
    logic [CW-1:0] perst_count;

    pcie_perst_sequencer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .PLL_TIMEOUT_CYC(PTO),
        .FABRIC_HOLD_CYC(FH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pcie_reset_n(pcie_reset_n), .pll_locked(pll_locked),
        .link_up(link_up), .hip_rst(hip_rst), .fabric_rst(fabric_rst), .afu_rst(afu_rst),
        .seq_state(seq_state), .pll_timeout(pll_timeout), .perst_count(perst_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase number, edge of entry, pin-delay queues
    logic q_p[$];
    logic q_l[$];
    int   m_n, m_st, m_enter, m_cnt;
    logic m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, m_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_p.delete();
        q_l.delete();
        for (int i = 0; i < SYNC; i++) begin
            q_p.push_back(1'b0);
            q_l.push_back(1'b0);
        end
        m_n = 0; m_st = 0; m_enter = 0; m_cnt = 0; m_to = 1'b0;
    endtask

    task automatic model_edge(input logic pin, input logic lock, input logic link);
        logic ps, ls;
        ps = q_p.pop_front();
        q_p.push_back(pin);
        ls = q_l.pop_front();
        q_l.push_back(lock);
        m_n++;
        if (!ps && m_st >= 2) begin
            m_st = 0;
            if (m_cnt < (2**CW) - 1) m_cnt++;
        end else if (!ls && m_st >= 3) begin
            m_st = 2; m_enter = m_n;
        end else if (!link && m_st >= 4) begin
            m_st = 3;
        end else begin
            case (m_st)
                0: if (ps) begin m_st = 1; m_enter = m_n; end
                1: if (!ps) m_st = 0;
                   else if (m_n - m_enter == DEB) begin m_st = 2; m_enter = m_n; end
                2: if (ls) m_st = 3;
                   else if (m_n - m_enter >= PTO) m_to = 1'b1;
                3: if (link) begin m_st = 4; m_enter = m_n; end
                4: if (m_n - m_enter == FH) m_st = 5;
                5: m_st = 6;
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("seq_state",   32'(seq_state),   32'(m_st));
        chk("hip_rst",     32'(hip_rst),     32'(m_st < 3));
        chk("fabric_rst",  32'(fabric_rst),  32'(m_st < 5));
        chk("afu_rst",     32'(afu_rst),     32'(m_st < 6));
        chk("pll_timeout", 32'(pll_timeout), 32'(m_to));
        chk("perst_count", 32'(perst_count), 32'(m_cnt));
    endtask

    task automatic step();
        logic p, l, k;
        p = pcie_reset_n; l = pll_locked; k = link_up;
        @(posedge clk);
        model_edge(p, l, k);
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int k;
        model_reset();

        // Reset state
        #12;
        check_model();
        #10 rst = 1'b0;
        pll_locked = 1'b1;
        steps(6);

        // Debounce glitch: 8 cycles high then low returns to hold, no count
        pcie_reset_n = 1'b1;
        steps(8);
        pcie_reset_n = 1'b0;
        steps(6);
        chk("glitch_state", 32'(seq_state), 32'd0);
        chk("glitch_count", 32'(perst_count), 32'd0);

        // Nominal bring-up
        pcie_reset_n = 1'b1;
        k = 0;
        do begin step(); k++; end while (hip_rst !== 1'b0 && k < 40);
        chk("hip_release_edge", 32'(k), 32'd21);
        steps(10);
        link_up = 1'b1;
        k = 0;
        do begin step(); k++; end while (fabric_rst !== 1'b0 && k < 60);
        chk("fabric_release_edge", 32'(k), 32'd33);
        step();
        chk("afu_release", 32'(afu_rst), 32'd0);
        chk("up_state", 32'(seq_state), 32'd6);

        // Link drop in S_UP
        link_up = 1'b0;
        steps(5);
        chk("linkdrop_hip", 32'(hip_rst), 32'd0);
        chk("linkdrop_fab", 32'(fabric_rst), 32'd1);
        link_up = 1'b1;
        k = 0;
        do begin step(); k++; end while (fabric_rst !== 1'b0 && k < 60);
        chk("relink_fabric_edge", 32'(k), 32'd33);
        step();
        chk("relink_afu", 32'(afu_rst), 32'd0);

        // PERST mid-operation, three full cycles
        for (int r = 0; r < 3; r++) begin
            pcie_reset_n = 1'b0;
            k = 0;
            do begin step(); k++; end while (hip_rst !== 1'b1 && k < 10);
            chk("perst_latency", 32'(k), 32'd4);
            chk("perst_count_r", 32'(perst_count), 32'(r + 1));
            pcie_reset_n = 1'b1;
            k = 0;
            do begin step(); k++; end while (seq_state !== 3'd6 && k < 200);
            chk("rebring_up", 32'(seq_state), 32'd6);
        end
        chk("perst_count_3", 32'(perst_count), 32'd3);

        // Simultaneous PERST and lock drop counts once
        pcie_reset_n = 1'b0;
        pll_locked   = 1'b0;
        steps(6);
        chk("prio_state", 32'(seq_state), 32'd0);
        chk("prio_count", 32'(perst_count), 32'd4);

        // PLL timeout, then late lock
        pcie_reset_n = 1'b1;
        k = 0;
        do begin step(); k++; end while (pll_timeout !== 1'b1 && k < 5000);
        chk("timeout_edge", 32'(k), 32'(4 + DEB + PTO));
        chk("timeout_hip", 32'(hip_rst), 32'd1);
        steps(20);
        pll_locked = 1'b1;
        k = 0;
        do begin step(); k++; end while (seq_state !== 3'd6 && k < 100);
        chk("late_lock_up", 32'(seq_state), 32'd6);
        chk("timeout_sticky", 32'(pll_timeout), 32'd1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pcie_reset_n = ~pcie_reset_n;
            if ($urandom_range(0, 59) == 0) pll_locked   = ~pll_locked;
            if ($urandom_range(0, 19) == 0) link_up      = ~link_up;
            step();
        end

        // Async reset in the middle of S_FABRIC
        pcie_reset_n = 1'b1;
        pll_locked   = 1'b1;
        link_up      = 1'b0;
        k = 0;
        do begin step(); k++; end while (seq_state !== 3'd3 && k < 300);
        chk("reach_hip", 32'(seq_state), 32'd3);
        link_up = 1'b1;
        steps(10);
        chk("in_fabric", 32'(seq_state), 32'd4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_hip", 32'(hip_rst), 32'd1);
        chk("arst_fab", 32'(fabric_rst), 32'd1);
        chk("arst_afu", 32'(afu_rst), 32'd1);
        chk("arst_state", 32'(seq_state), 32'd0);
        chk("arst_timeout", 32'(pll_timeout), 32'd0);
        chk("arst_count", 32'(perst_count), 32'd0);
        #3 rst = 1'b0;
        steps(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_perst_sequencer.md
Name: pcie_perst_sequencer

Overview:
- Device-side responder to the platform PCIe reset/refclk stimulus.
- Receives the asynchronous PCIE_RESET_N (PERST#) from the board/bench and the IOPLL lock, and generates ordered, registered resets: PCIe HIP first, then FIM fabric, then AFU.
- Sits in the top-level reset tree, between the board pins and the PCIe subsystem / fabric reset consumers.
- Reports sequence state, PLL-lock timeout and a count of PERST assertions.

Parameters:
- SYNC_STAGES, 3: synchronizer depth for pcie_reset_n and pll_locked (minimum 2).
- DEBOUNCE_CYC, 16: consecutive clk cycles PERST must stay deasserted before the sequence advances (minimum 1).
- PLL_TIMEOUT_CYC, 4096: cycles in S_PLL before pll_timeout is set.
- FABRIC_HOLD_CYC, 32: cycles fabric_rst is held after link_up before release (minimum 1).
- CNT_W, 16: width of perst_count.

Ports:
- clk  in  1  free-running system clock (100 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- pcie_reset_n  in  1  PERST#, asynchronous, active-low; synchronized internally.
- pll_locked  in  1  IOPLL lock, asynchronous; synchronized internally.
- link_up  in  1  HIP link-up/DL-active, synchronous to clk.
- hip_rst  out  1  active-high reset to the PCIe HIP.
- fabric_rst  out  1  active-high reset to the FIM fabric.
- afu_rst  out  1  active-high reset to the AFU / port.
- seq_state  out  3  current state encoding.
- pll_timeout  out  1  sticky flag: lock not seen within PLL_TIMEOUT_CYC.
- perst_count  out  CNT_W  number of PERST assertions seen outside S_HOLD; saturates.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=S_HOLD; hip_rst=fabric_rst=afu_rst=1; pll_timeout=0; perst_count=0.
  - All counters are 0. Synchronizer flops clear to 0, i.e. PERST asserted and PLL unlocked.
- Synchronizers: perst_s and lock_s are the last flop of a SYNC_STAGES chain. Nothing else is sampled combinationally from the asynchronous pins.
- All outputs are registered. On every transition the outputs are computed from the next state, so they change on the same edge the state changes.
- States and transitions:
  - S_HOLD (0): all resets 1. perst_s=1 -> S_DEBOUNCE, cnt=0.
  - S_DEBOUNCE (1): all resets 1.
    - perst_s=0 -> S_HOLD; perst_count is not incremented (glitch).
    - Otherwise cnt++. When cnt==DEBOUNCE_CYC-1 -> S_PLL, cnt=0.
  - S_PLL (2): all resets 1.
    - lock_s=1 -> S_HIP.
    - Otherwise cnt++. At cnt==PLL_TIMEOUT_CYC-1, set pll_timeout and stay in S_PLL; the counter holds and the block keeps waiting.
  - S_HIP (3): hip_rst=0, fabric_rst=afu_rst=1. link_up=1 -> S_FABRIC, cnt=0.
  - S_FABRIC (4): hip_rst=0, fabric_rst=afu_rst=1.
    - cnt++. When cnt==FABRIC_HOLD_CYC-1 -> S_AFU.
  - S_AFU (5): hip_rst=fabric_rst=0, afu_rst=1. Stays exactly 1 cycle -> S_UP.
  - S_UP (6): all resets 0. Steady state.
- Abort conditions, evaluated every cycle in priority order:
  1. perst_s=0 in any state other than S_HOLD/S_DEBOUNCE -> S_HOLD; all resets 1 on that edge; perst_count++ (saturate at all-ones).
  2. lock_s=0 in S_HIP, S_FABRIC, S_AFU or S_UP -> S_PLL, cnt=0; all resets 1. pll_timeout is unchanged.
  3. link_up=0 in S_FABRIC, S_AFU or S_UP -> S_HIP; hip_rst stays 0; fabric_rst=afu_rst=1.
- Simultaneous events: the higher priority wins. A PERST drop together with a lock drop counts once and goes to S_HOLD.
- pll_timeout clears only on rst.
- Reset ordering invariant, every cycle:
  - hip_rst=1 implies fabric_rst=1 and afu_rst=1.
  - fabric_rst=1 implies afu_rst=1.
  - Deassertion order is hip, then fabric, then afu. Assertion of all three may occur together.
- Counters are sized as clog2(max parameter)+1 and must never wrap.
- Latency: a PERST assertion reaches the outputs within SYNC_STAGES+1 clk edges.

Test Plan:
- Nominal bring-up:
  - Stimulus: rst released; pll_locked=1 held; pcie_reset_n rises at edge 0; link_up rises 10 cycles after hip_rst falls.
  - Response: hip_rst falls at edge 21 (+1 for sync uncertainty). fabric_rst falls 32 cycles after link_up is sampled. afu_rst falls 1 cycle later. seq_state=6.
- Debounce glitch:
  - Stimulus: pcie_reset_n high for 8 cycles, then low, then high for good.
  - Response: returns to S_HOLD; perst_count stays 0; bring-up completes only after 16 clean cycles.
- PLL timeout:
  - Stimulus: pll_locked=0 while PERST is released.
  - Response: pll_timeout=1 after 4096 cycles in S_PLL; all resets stay 1. Lock rises later, the sequence completes and pll_timeout remains 1.
- PERST mid-operation:
  - Stimulus: in S_UP, pcie_reset_n falls.
  - Response: all resets 1 within 4 edges; seq_state=0; perst_count=1. Repeating the full cycle 3 times gives perst_count=3.
- Link drop:
  - Stimulus: in S_UP, link_up=0 for 5 cycles, then 1.
  - Response: hip_rst stays 0; fabric_rst and afu_rst are 1. After link_up returns, fabric_rst releases 32 cycles later, then afu_rst 1 cycle after that.
- Priority and async reset:
  - Stimulus: pcie_reset_n and pll_locked fall on the same cycle. Then assert rst in the middle of S_FABRIC.
  - Response: S_HOLD with perst_count incremented by 1. rst immediately forces all resets to 1, pll_timeout=0 and perst_count=0 without waiting for a clk edge.
